ex_stage: RTL and testbench

// - Execute stage of the 64-bit pipeline: consumes the ID_EX register outputs, computes ALU result or

---
 rtl/ex_pkg.sv | 90 +++++++++
 rtl/ex_mul_iter.sv | 96 +++++++++
 rtl/ex_stage.sv | 193 +++++++++++++++++++
 tb/tb_ex_stage.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
`default_nettype none
//============================================================================
// Module   : ex_pkg
// Purpose  : Shared types and helpers for the execute stage: datapath width
//            and multiplier step defaults, Aluop codes, ALU operation codes
//            (funct_in encoding), multiplier FSM states, and forwarding-source
//            selection.
// Revision : 1.0 - initial release
//============================================================================
package ex_pkg;

   localparam int c_XLEN     = 64;
   localparam int c_MUL_STEP = 4;

   // Aluop_in encodings
   localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
   localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
   localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] c_ALUOP_ADD2  = 2'b11;

   // funct_in = {funct7[5], funct3}
   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b1000,
      ALU_AND  = 4'b0111,
      ALU_OR   = 4'b0110,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0001,
      ALU_SRL  = 4'b0101,
      ALU_SRA  = 4'b1101,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011
   } alu_op_e;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

   typedef enum logic [1:0] {
      FWD_RF    = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_e;

   // Unknown funct codes fall back to add.
   function automatic alu_op_e alu_decode(input logic [1:0] aluop,
                                          input logic [3:0] funct);
      alu_op_e op;
      op = ALU_ADD;
      case (aluop)
         c_ALUOP_ADD, c_ALUOP_ADD2: op = ALU_ADD;
         c_ALUOP_SUB:               op = ALU_SUB;
         c_ALUOP_FUNCT: begin
            case (funct)
               4'b1000: op = ALU_SUB;
               4'b0111: op = ALU_AND;
               4'b0110: op = ALU_OR;
               4'b0100: op = ALU_XOR;
               4'b0001: op = ALU_SLL;
               4'b0101: op = ALU_SRL;
               4'b1101: op = ALU_SRA;
               4'b0010: op = ALU_SLT;
               4'b0011: op = ALU_SLTU;
               default: op = ALU_ADD;
            endcase
         end
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   // The younger producer (EX/MEM) wins; x0 is never forwarded.
   function automatic fwd_sel_e fwd_select(input logic       exmem_we,
                                           input logic [4:0] exmem_rd,
                                           input logic       memwb_we,
                                           input logic [4:0] memwb_rd,
                                           input logic [4:0] rs);
      fwd_sel_e sel;
      sel = FWD_RF;
      if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == rs))
         sel = FWD_EXMEM;
      else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == rs))
         sel = FWD_MEMWB;
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mul_iter.sv
`default_nettype none
//============================================================================
// Module   : ex_mul_iter
// Purpose  : Iterative radix-2^MUL_STEP shift-add multiplier returning the
//            low XLEN bits of the product. IDLE -> BUSY on i_start, retires
//            MUL_STEP multiplier bits per BUSY cycle for XLEN/MUL_STEP cycles,
//            then presents the product for one cycle in DONE. i_flush returns
//            to IDLE from any state. MUL_STEP must divide XLEN.
// Ports    : clk, rst        clock, synchronous active-high reset
//            i_start         load operands and begin (only honoured in IDLE)
//            i_flush         abandon the current operation
//            i_a, i_b        multiplicand, multiplier (XLEN)
//            o_idle/o_busy/o_done  FSM state flags
//            o_product       low XLEN bits of i_a*i_b, valid while o_done
// Revision : 1.0 - initial release
//============================================================================
module ex_mul_iter
   import ex_pkg::*;
#(
   parameter int XLEN     = c_XLEN,
   parameter int MUL_STEP = c_MUL_STEP
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_idle,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_product
);
   localparam int              c_N    = XLEN / MUL_STEP;
   localparam int              c_CW   = (c_N > 1) ? $clog2(c_N) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

   mul_state_e       r_state;
   mul_state_e       w_state_nxt;
   logic [XLEN-1:0]  r_a;
   logic [XLEN-1:0]  r_b;
   logic [XLEN-1:0]  r_acc;
   logic [c_CW-1:0]  r_cnt;
   logic [XLEN-1:0]  w_partial;

   always_ff @(posedge clk) begin
      if (rst) r_state <= MUL_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         MUL_IDLE: if (i_start)          w_state_nxt = MUL_BUSY;
         MUL_BUSY: if (r_cnt == c_LAST)  w_state_nxt = MUL_DONE;
         MUL_DONE:                       w_state_nxt = MUL_IDLE;
         default:                        w_state_nxt = MUL_IDLE;
      endcase
      if (i_flush) w_state_nxt = MUL_IDLE;
   end

   // Partial product for the current MUL_STEP-bit digit: r_a is already
   // shifted to the digit's weight, so only the in-digit shifts remain.
   always_comb begin
      w_partial = '0;
      for (int i = 0; i < MUL_STEP; i++) begin
         if (r_b[i]) w_partial = w_partial + (r_a << i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
         r_cnt <= '0;
      end else if ((r_state == MUL_IDLE) && i_start) begin
         r_a   <= i_a;
         r_b   <= i_b;
         r_acc <= '0;
         r_cnt <= '0;
      end else if (r_state == MUL_BUSY) begin
         r_acc <= r_acc + w_partial;
         r_a   <= r_a << MUL_STEP;
         r_b   <= r_b >> MUL_STEP;
         r_cnt <= r_cnt + c_CW'(1);
      end
   end

   assign o_idle    = (r_state == MUL_IDLE);
   assign o_busy    = (r_state == MUL_BUSY);
   assign o_done    = (r_state == MUL_DONE);
   assign o_product = r_acc;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
//============================================================================
// Module   : ex_stage
// Purpose  : Execute stage of the 64-bit pipeline. Selects operands (with
//            optional forwarding), computes the single-cycle ALU result or
//            runs the iterative multiplier, and registers the EX/MEM fields.
//            Raises stall_out while a multiply occupies the stage.
// Config   : EX_FWD_EN - when defined, operands are forwarded from EX/MEM
//            (priority) or MEM/WB; otherwise the forwarding ports are ignored.
// Ports    : clk, rst                      clock, synchronous active-high reset
//            AluSrc/MemtoReg/RegWrite/MemRead/MemWrite_in  ID_EX control
//            Aluop_in[1:0], funct_in[3:0]  ALU operation select
//            mul_in                        instruction is MUL (low half)
//            rs1Data/rs2Data/immediate_in  operands (XLEN)
//            rs_in, rt_in, rd_in           register indices
//            flush_in                      kill the instruction in EX
//            exmem_fwd_*, memwb_fwd_*      forwarding sources
//            RegWrite/MemtoReg/MemRead/MemWrite_out  EX/MEM control
//            alu_result_out, store_data_out, rd_out, zero_out  EX/MEM data
//            stall_out                     combinational upstream hold
// Revision : 1.0 - initial release
//============================================================================
module ex_stage
   import ex_pkg::*;
#(
   parameter int XLEN     = c_XLEN,
   parameter int MUL_STEP = c_MUL_STEP
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            AluSrc_in,
   input  logic            MemtoReg_in,
   input  logic            RegWrite_in,
   input  logic            MemRead_in,
   input  logic            MemWrite_in,
   input  logic [1:0]      Aluop_in,
   input  logic [3:0]      funct_in,
   input  logic            mul_in,
   input  logic [XLEN-1:0] rs1Data_in,
   input  logic [XLEN-1:0] rs2Data_in,
   input  logic [XLEN-1:0] immediate_in,
   input  logic [4:0]      rs_in,
   input  logic [4:0]      rt_in,
   input  logic [4:0]      rd_in,
   input  logic            flush_in,
   input  logic            exmem_fwd_we,
   input  logic            memwb_fwd_we,
   input  logic [4:0]      exmem_fwd_rd,
   input  logic [4:0]      memwb_fwd_rd,
   input  logic [XLEN-1:0] exmem_fwd_data,
   input  logic [XLEN-1:0] memwb_fwd_data,
   output logic            RegWrite_out,
   output logic            MemtoReg_out,
   output logic            MemRead_out,
   output logic            MemWrite_out,
   output logic [XLEN-1:0] alu_result_out,
   output logic [XLEN-1:0] store_data_out,
   output logic [4:0]      rd_out,
   output logic            zero_out,
   output logic            stall_out
);
   localparam int c_SHW = $clog2(XLEN);

   logic [XLEN-1:0]  w_rs1_fwd;
   logic [XLEN-1:0]  w_rs2_fwd;
   logic [XLEN-1:0]  w_op_b;
   logic [XLEN-1:0]  w_alu_res;
   logic [XLEN-1:0]  w_mul_product;
   logic [c_SHW-1:0] w_shamt;
   alu_op_e          w_alu_op;
   logic             w_mul_idle;
   logic             w_mul_busy;
   logic             w_mul_done;
   logic             w_mul_start;
   logic [3:0]       r_hold_ctrl;
   logic [4:0]       r_hold_rd;
   logic [XLEN-1:0]  r_hold_store;

`ifdef EX_FWD_EN
   fwd_sel_e w_sel_a;
   fwd_sel_e w_sel_b;

   assign w_sel_a = fwd_select(exmem_fwd_we, exmem_fwd_rd, memwb_fwd_we, memwb_fwd_rd, rs_in);
   assign w_sel_b = fwd_select(exmem_fwd_we, exmem_fwd_rd, memwb_fwd_we, memwb_fwd_rd, rt_in);

   always_comb begin
      w_rs1_fwd = rs1Data_in;
      w_rs2_fwd = rs2Data_in;
      case (w_sel_a)
         FWD_EXMEM: w_rs1_fwd = exmem_fwd_data;
         FWD_MEMWB: w_rs1_fwd = memwb_fwd_data;
         default:   w_rs1_fwd = rs1Data_in;
      endcase
      case (w_sel_b)
         FWD_EXMEM: w_rs2_fwd = exmem_fwd_data;
         FWD_MEMWB: w_rs2_fwd = memwb_fwd_data;
         default:   w_rs2_fwd = rs2Data_in;
      endcase
   end
`else
   logic w_unused_fwd;

   assign w_rs1_fwd    = rs1Data_in;
   assign w_rs2_fwd    = rs2Data_in;
   assign w_unused_fwd = ^{exmem_fwd_we, memwb_fwd_we, exmem_fwd_rd, memwb_fwd_rd,
                           exmem_fwd_data, memwb_fwd_data, rs_in, rt_in};
`endif

   assign w_op_b   = AluSrc_in ? immediate_in : w_rs2_fwd;
   assign w_alu_op = alu_decode(Aluop_in, funct_in);
   assign w_shamt  = w_op_b[c_SHW-1:0];

   always_comb begin
      w_alu_res = w_rs1_fwd + w_op_b;
      case (w_alu_op)
         ALU_ADD:  w_alu_res = w_rs1_fwd + w_op_b;
         ALU_SUB:  w_alu_res = w_rs1_fwd - w_op_b;
         ALU_AND:  w_alu_res = w_rs1_fwd & w_op_b;
         ALU_OR:   w_alu_res = w_rs1_fwd | w_op_b;
         ALU_XOR:  w_alu_res = w_rs1_fwd ^ w_op_b;
         ALU_SLL:  w_alu_res = w_rs1_fwd << w_shamt;
         ALU_SRL:  w_alu_res = w_rs1_fwd >> w_shamt;
         ALU_SRA:  w_alu_res = $unsigned($signed(w_rs1_fwd) >>> w_shamt);
         ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_rs1_fwd) < $signed(w_op_b))};
         ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (w_rs1_fwd < w_op_b)};
         default:  w_alu_res = w_rs1_fwd + w_op_b;
      endcase
   end

   // A flush in the same cycle as a MUL suppresses the start.
   assign w_mul_start = w_mul_idle & mul_in & ~flush_in;

   ex_mul_iter #(
      .XLEN     (XLEN),
      .MUL_STEP (MUL_STEP)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_mul_start),
      .i_flush   (flush_in),
      .i_a       (w_rs1_fwd),
      .i_b       (w_op_b),
      .o_idle    (w_mul_idle),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   // Covers the start cycle plus every BUSY cycle; DONE releases upstream.
   assign stall_out = ~rst & ~flush_in & ((w_mul_idle & mul_in) | w_mul_busy);

   // EX/MEM fields of the MUL are captured at start so the write-back in
   // DONE does not depend on what ID_EX holds by then.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_ctrl  <= '0;
         r_hold_rd    <= '0;
         r_hold_store <= '0;
      end else if (w_mul_start) begin
         r_hold_ctrl  <= {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in};
         r_hold_rd    <= rd_in;
         r_hold_store <= w_rs2_fwd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out} <= 4'b0000;
         alu_result_out <= '0;
         store_data_out <= '0;
         rd_out         <= '0;
         zero_out       <= 1'b0;
      end else if (flush_in || w_mul_start || w_mul_busy) begin
         // Bubble: control cleared, data fields keep their last values.
         {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out} <= 4'b0000;
      end else if (w_mul_done) begin
         {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out} <= r_hold_ctrl;
         alu_result_out <= w_mul_product;
         store_data_out <= r_hold_store;
         rd_out         <= r_hold_rd;
         zero_out       <= (w_mul_product == '0);
      end else begin
         {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out} <=
            {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in};
         alu_result_out <= w_alu_res;
         store_data_out <= w_rs2_fwd;
         rd_out         <= rd_in;
         zero_out       <= (w_alu_res == '0);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
//============================================================================
// Module   : tb_ex_stage
// Purpose  : Self-checking bench for ex_stage. Expected EX/MEM contents are
//            queued as instructions are issued; a monitor pops and compares
//            whenever the stage emits a non-bubble. Directed cases plus a
//            randomized mix of ALU ops, multiplies and flushes.
// Revision : 1.0 - initial release
//============================================================================
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        AluSrc_in, MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in;
   logic [1:0]  Aluop_in;
   logic [3:0]  funct_in;
   logic        mul_in;
   logic [63:0] rs1Data_in, rs2Data_in, immediate_in;
   logic [4:0]  rs_in, rt_in, rd_in;
   logic        flush_in;
   logic        exmem_fwd_we, memwb_fwd_we;
   logic [4:0]  exmem_fwd_rd, memwb_fwd_rd;
   logic [63:0] exmem_fwd_data, memwb_fwd_data;
   logic        RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;
   logic [63:0] alu_result_out, store_data_out;
   logic [4:0]  rd_out;
   logic        zero_out;
   logic        stall_out;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst(rst),
      .AluSrc_in(AluSrc_in), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .Aluop_in(Aluop_in), .funct_in(funct_in), .mul_in(mul_in),
      .rs1Data_in(rs1Data_in), .rs2Data_in(rs2Data_in), .immediate_in(immediate_in),
      .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush_in(flush_in),
      .exmem_fwd_we(exmem_fwd_we), .memwb_fwd_we(memwb_fwd_we),
      .exmem_fwd_rd(exmem_fwd_rd), .memwb_fwd_rd(memwb_fwd_rd),
      .exmem_fwd_data(exmem_fwd_data), .memwb_fwd_data(memwb_fwd_data),
      .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
      .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
      .alu_result_out(alu_result_out), .store_data_out(store_data_out),
      .rd_out(rd_out), .zero_out(zero_out), .stall_out(stall_out)
   );

   typedef struct packed {
      logic [3:0]  ctrl;   // {RegWrite, MemtoReg, MemRead, MemWrite}
      logic [63:0] res;
      logic [63:0] st;
      logic [4:0]  rd;
      logic        z;
   } exp_t;

   exp_t q[$];
   exp_t m_got;
   exp_t m_exp;
   int   errors = 0;
   int   checks = 0;

   // ---------------- reference model ----------------
   function automatic logic [63:0] r64();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [63:0] ref_alu(input logic [1:0] aluop, input logic [3:0] f,
                                           input logic [63:0] a, input logic [63:0] b);
      logic signed [63:0] sa, sb;
      int unsigned sh;
      sa = a;
      sb = b;
      sh = b % 64;
      if (aluop == 2'b01) return a - b;
      if (aluop != 2'b10) return a + b;
      case (f)
         4'b1000: return a - b;
         4'b0111: return a & b;
         4'b0110: return a | b;
         4'b0100: return a ^ b;
         4'b0001: return a << sh;
         4'b0101: return a >> sh;
         4'b1101: return sa >>> sh;
         4'b0010: return (sa < sb) ? 64'd1 : 64'd0;
         4'b0011: return (a < b) ? 64'd1 : 64'd0;
         default: return a + b;
      endcase
   endfunction

   // Register value as seen by EX after forwarding.
   function automatic logic [63:0] src(input logic [4:0] r, input logic [63:0] rf);
`ifdef EX_FWD_EN
      if (exmem_fwd_we && r != 5'd0 && r == exmem_fwd_rd) return exmem_fwd_data;
      if (memwb_fwd_we && r != 5'd0 && r == memwb_fwd_rd) return memwb_fwd_data;
`endif
      return rf;
   endfunction

   // Expected EX/MEM contents for the instruction currently presented.
   function automatic exp_t cur_expect();
      exp_t e;
      logic [63:0] a, s2, b;
      a  = src(rs_in, rs1Data_in);
      s2 = src(rt_in, rs2Data_in);
      b  = AluSrc_in ? immediate_in : s2;
      e.ctrl = {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in};
      e.res  = mul_in ? (a * b) : ref_alu(Aluop_in, funct_in, a, b);
      e.st   = s2;
      e.rd   = rd_in;
      e.z    = (e.res == 64'd0);
      return e;
   endfunction

   function automatic exp_t mk(input logic [3:0] c, input logic [63:0] r, input logic [63:0] s,
                               input logic [4:0] d, input logic z);
      exp_t e;
      e.ctrl = c; e.res = r; e.st = s; e.rd = d; e.z = z;
      return e;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if ({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out} != 4'b0000) begin
         m_got = mk({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out},
                    alu_result_out, store_data_out, rd_out, zero_out);
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got ctrl=%b res=%h rd=%0d, required no output",
                     m_got.ctrl, m_got.res, m_got.rd);
         end else begin
            m_exp = q.pop_front();
            if (m_got !== m_exp) begin
               errors++;
               $display("FAIL scoreboard: got ctrl=%b res=%h st=%h rd=%0d z=%b, required ctrl=%b res=%h st=%h rd=%0d z=%b",
                        m_got.ctrl, m_got.res, m_got.st, m_got.rd, m_got.z,
                        m_exp.ctrl, m_exp.res, m_exp.st, m_exp.rd, m_exp.z);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic apply(input logic [1:0] aluop, input logic [3:0] funct,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                        input logic alusrc, input logic [3:0] ctrl,
                        input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                        input logic mul);
      Aluop_in = aluop; funct_in = funct;
      rs1Data_in = a; rs2Data_in = b; immediate_in = imm; AluSrc_in = alusrc;
      {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in} = ctrl;
      rd_in = rd; rs_in = rs; rt_in = rt; mul_in = mul; flush_in = 1'b0;
   endtask

   task automatic no_fwd();
      exmem_fwd_we = 1'b0; memwb_fwd_we = 1'b0;
      exmem_fwd_rd = 5'd0; memwb_fwd_rd = 5'd0;
      exmem_fwd_data = 64'd0; memwb_fwd_data = 64'd0;
   endtask

   task automatic rand_fwd();
      exmem_fwd_we = 1'($urandom_range(0, 1)); memwb_fwd_we = 1'($urandom_range(0, 1));
      exmem_fwd_rd = 5'($urandom_range(0, 7)); memwb_fwd_rd = 5'($urandom_range(0, 7));
      exmem_fwd_data = r64(); memwb_fwd_data = r64();
   endtask

   task automatic rand_instr(input logic mul);
      logic [63:0] a, b, imm;
      a = r64(); b = r64(); imm = r64();
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 80));
      if ($urandom_range(0, 3) == 0) imm = 64'($urandom_range(0, 80));
      if ($urandom_range(0, 7) == 0) b = a;
      apply(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), a, b, imm,
            mul ? 1'b0 : 1'($urandom_range(0, 1)), {1'b1, 3'($urandom_range(0, 7))},
            5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), mul);
   endtask

   // Called at posedge+1 with an instruction presented; returns at posedge+1
   // after the edge that writes it into EX/MEM. stalls = cycles stall_out held.
   task automatic step(output int stalls);
      stalls = 0;
      #1;
      while (stall_out === 1'b1 && stalls < 100) begin
         stalls++;
         @(posedge clk);
         #2;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   initial begin
      int s;
      rst = 1'b1;
      no_fwd();
      apply(2'b00, 4'h0, 64'd0, 64'd0, 64'd0, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);

      // Reset dominates random activity, including MUL and flush requests.
      for (int i = 0; i < 3; i++) begin
         rand_fwd();
         rand_instr(1'b1);
         flush_in = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         chk("reset_ctrl_zero", {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, zero_out}, 64'd0);
         chk("reset_result", alu_result_out, 64'd0);
         chk("reset_store", store_data_out, 64'd0);
         chk("reset_rd", rd_out, 64'd0);
         chk("reset_stall", stall_out, 64'd0);
      end
      rst = 1'b0;
      no_fwd();

      // Arithmetic shift right of the sign bit by an immediate of 4.
      apply(2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 1'b1, 4'b1000, 5'd3, 5'd1, 5'd2, 1'b0);
      q.push_back(mk(4'b1000, 64'hF800_0000_0000_0000, 64'd0, 5'd3, 1'b0));
      step(s);
      chk("sra_stall", s, 0);

      // Subtraction of equal operands sets zero.
      apply(2'b01, 4'b0000, 64'h1234, 64'h1234, 64'd0, 1'b0, 4'b1010, 5'd4, 5'd1, 5'd2, 1'b0);
      q.push_back(mk(4'b1010, 64'd0, 64'h1234, 5'd4, 1'b1));
      step(s);
      chk("sub_zero_flag", zero_out, 64'd1);

      // Signed compare: -1 < 1.
      apply(2'b10, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 4'b1000, 5'd5, 5'd1, 5'd2, 1'b0);
      q.push_back(mk(4'b1000, 64'd1, 64'd1, 5'd5, 1'b0));
      step(s);

      // Undefined funct falls back to add.
      apply(2'b10, 4'b1111, 64'd7, 64'd5, 64'd0, 1'b0, 4'b1001, 5'd6, 5'd1, 5'd2, 1'b0);
      q.push_back(mk(4'b1001, 64'd12, 64'd5, 5'd6, 1'b0));
      step(s);

      // Multiply: N+1 = 17 stall cycles, result in EX/MEM right after DONE.
      apply(2'b10, 4'b0000, 64'h0000_0001_0000_0003, 64'd5, 64'd0, 1'b0, 4'b1000, 5'd7, 5'd8, 5'd9, 1'b1);
      q.push_back(mk(4'b1000, 64'h0000_0005_0000_000F, 64'd5, 5'd7, 1'b0));
      step(s);
      chk("mul_stall_cycles", s, 17);
      chk("mul_regwrite", RegWrite_out, 64'd1);
      chk("mul_result", alu_result_out, 64'h0000_0005_0000_000F);

      // Flush in the fifth BUSY cycle: nothing written, FSM back to IDLE.
      rand_instr(1'b1);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("mul_busy_stall", stall_out, 64'd1);
         @(posedge clk);
         #1;
      end
      flush_in = 1'b1;
      #1;
      chk("flush_stall_low", stall_out, 64'd0);
      @(posedge clk);
      #1;
      chk("flush_bubble", {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out}, 64'd0);
      rand_instr(1'b0);
      q.push_back(cur_expect());
      step(s);
      chk("post_flush_idle", s, 0);

      // Flush together with a MUL in IDLE: no multiply starts.
      rand_instr(1'b1);
      flush_in = 1'b1;
      #1;
      chk("flush_mul_stall", stall_out, 64'd0);
      @(posedge clk);
      #1;
      chk("flush_mul_bubble", {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out}, 64'd0);
      rand_instr(1'b0);
      q.push_back(cur_expect());
      step(s);
      chk("flush_mul_no_start", s, 0);

`ifdef EX_FWD_EN
      // EX/MEM outranks MEM/WB for the same register; x0 is never forwarded.
      exmem_fwd_we = 1'b1; exmem_fwd_rd = 5'd5; exmem_fwd_data = 64'hAA;
      memwb_fwd_we = 1'b1; memwb_fwd_rd = 5'd5; memwb_fwd_data = 64'hBB;
      apply(2'b00, 4'b0000, 64'h1111, 64'h0, 64'd0, 1'b1, 4'b1000, 5'd6, 5'd5, 5'd0, 1'b0);
      q.push_back(mk(4'b1000, 64'hAA, 64'h0, 5'd6, 1'b0));
      step(s);
      exmem_fwd_rd = 5'd0; memwb_fwd_rd = 5'd0;
      apply(2'b00, 4'b0000, 64'h33, 64'h44, 64'd0, 1'b1, 4'b1000, 5'd6, 5'd0, 5'd0, 1'b0);
      q.push_back(mk(4'b1000, 64'h33, 64'h44, 5'd6, 1'b0));
      step(s);
`endif

      // Randomized mix.
      for (int n = 0; n < 160; n++) begin
         rand_fwd();
         if (n % 20 == 13) begin
            rand_instr(1'b1);
            q.push_back(cur_expect());
            step(s);
            chk("rand_mul_stall", s, 17);
         end else if (n % 9 == 4) begin
            rand_instr(1'b0);
            flush_in = 1'b1;
            @(posedge clk);
            #1;
            chk("rand_flush_bubble", {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out}, 64'd0);
         end else begin
            rand_instr(1'b0);
            q.push_back(cur_expect());
            step(s);
            chk("rand_alu_stall", s, 0);
         end
      end

      apply(2'b00, 4'h0, 64'd0, 64'd0, 64'd0, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drain", q.size(), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
